// File: rtl/neuron_train_sequencer_if.sv
// neuron_train_sequencer_if: control, status and datapath-strobe bundle.
// master = neuron top level / datapath side, slave = training sequencer.
interface neuron_train_sequencer_if #(
  parameter int ADDR_W  = 8,
  parameter int EPOCH_W = 16
);
  logic               start;
  logic               abort;
  logic [ADDR_W:0]    nSamples;
  logic [EPOCH_W-1:0] maxEpochs;
  logic               eqFlag;
  logic [ADDR_W-1:0]  memAddr;
  logic               memRdEn;
  logic               ldX1;
  logic               ldX2;
  logic               ldt;
  logic               ldYin;
  logic               ldW1;
  logic               ldW2;
  logic               ldB;
  logic               initW1;
  logic               initW2;
  logic               initB;
  logic [EPOCH_W-1:0] epochCount;
  logic               busy;
  logic               done;
  logic               converged;

  modport master (
    output start, abort, nSamples, maxEpochs, eqFlag,
    input  memAddr, memRdEn, ldX1, ldX2, ldt, ldYin,
    input  ldW1, ldW2, ldB, initW1, initW2, initB,
    input  epochCount, busy, done, converged
  );

  modport slave (
    input  start, abort, nSamples, maxEpochs, eqFlag,
    output memAddr, memRdEn, ldX1, ldX2, ldt, ldYin,
    output ldW1, ldW2, ldB, initW1, initW2, initB,
    output epochCount, busy, done, converged
  );
endinterface

// File: rtl/neuron_train_sequencer.sv
// neuron_train_sequencer: multi-epoch perceptron training sequencer.
// Ports: clk, rstN (async low), bus (slave): start/abort/nSamples/
// maxEpochs/eqFlag in; memory, datapath strobes and status out.
module neuron_train_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int EPOCH_W = 16
) (
  input  logic                   clk,
  input  logic                   rstN,
  neuron_train_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_FETCH, S_LOAD, S_EVAL,
    S_DECIDE, S_UPDATE, S_NEXT, S_EPOCH, S_DONE
  } state_e;

  localparam logic [ADDR_W:0] MAX_S =
    {1'b1, {ADDR_W{1'b0}}};
  localparam logic [EPOCH_W-1:0] EP_MAX = '1;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [EPOCH_W-1:0] ep_q, ep_d;
  logic [EPOCH_W-1:0] maxe_q, maxe_d;
  logic [ADDR_W:0]    ns_q, ns_d;
  logic               upd_q, upd_d;
  logic               conv_q, conv_d;
  logic               busy_q, done_q;
  logic               init_q, rd_q;
  logic               ldx_q, ldy_q, ldw_q;

  logic [ADDR_W:0]    ns_clamp;
  logic               is_last;
  logic               ep_hit;
  logic               busy_st;

  assign ns_clamp = (bus.nSamples > MAX_S) ? MAX_S
                                           : bus.nSamples;
  assign is_last  = {1'b0, idx_q} ==
                    (ns_q - (ADDR_W+1)'(1));
  // Compare one bit wider so a saturated count never
  // wraps onto the limit.
  assign ep_hit   = (maxe_q != '0) &&
                    (({1'b0, ep_q} + (EPOCH_W+1)'(1)) ==
                     {1'b0, maxe_q});
  assign busy_st  = (state_q != S_IDLE) &&
                    (state_q != S_DONE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ep_d    = ep_q;
    upd_d   = upd_q;
    conv_d  = conv_q;
    ns_d    = ns_q;
    maxe_d  = maxe_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          ns_d    = ns_clamp;
          maxe_d  = bus.maxEpochs;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        idx_d = '0;
        ep_d  = '0;
        upd_d = 1'b0;
        if (ns_q == '0) begin
          conv_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          conv_d  = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH:  state_d = S_LOAD;
      S_LOAD:   state_d = S_EVAL;
      S_EVAL:   state_d = S_DECIDE;
      S_DECIDE: state_d = bus.eqFlag ? S_NEXT : S_UPDATE;
      S_UPDATE: begin
        upd_d   = 1'b1;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (is_last) begin
          state_d = S_EPOCH;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      S_EPOCH: begin
        if (ep_q != EP_MAX) ep_d = ep_q + EPOCH_W'(1);
        if (!upd_q) begin
          conv_d  = 1'b1;
          state_d = S_DONE;
        end else if (ep_hit) begin
          conv_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          idx_d   = '0;
          upd_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          ns_d    = ns_clamp;
          maxe_d  = bus.maxEpochs;
          conv_d  = 1'b0;
          state_d = S_INIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // abort wins over every transition of a busy state
    if (bus.abort && busy_st) begin
      state_d = S_IDLE;
      conv_d  = 1'b0;
    end
  end

  // Strobes are decoded from the next state so they are
  // registered yet line up exactly with the current state.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ep_q    <= '0;
      maxe_q  <= '0;
      ns_q    <= '0;
      upd_q   <= 1'b0;
      conv_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      init_q  <= 1'b0;
      rd_q    <= 1'b0;
      ldx_q   <= 1'b0;
      ldy_q   <= 1'b0;
      ldw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ep_q    <= ep_d;
      maxe_q  <= maxe_d;
      ns_q    <= ns_d;
      upd_q   <= upd_d;
      conv_q  <= conv_d;
      busy_q  <= (state_d != S_IDLE) &&
                 (state_d != S_DONE);
      done_q  <= state_d == S_DONE;
      init_q  <= state_d == S_INIT;
      rd_q    <= state_d == S_FETCH;
      ldx_q   <= state_d == S_LOAD;
      ldy_q   <= state_d == S_EVAL;
      ldw_q   <= state_d == S_UPDATE;
    end
  end

  assign bus.memAddr    = idx_q;
  assign bus.memRdEn    = rd_q;
  assign bus.ldX1       = ldx_q;
  assign bus.ldX2       = ldx_q;
  assign bus.ldt        = ldx_q;
  assign bus.ldYin      = ldy_q;
  assign bus.ldW1       = ldw_q;
  assign bus.ldW2       = ldw_q;
  assign bus.ldB        = ldw_q;
  assign bus.initW1     = init_q;
  assign bus.initW2     = init_q;
  assign bus.initB      = init_q;
  assign bus.epochCount = ep_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.converged  = conv_q;

endmodule

// File: doc/neuron_train_sequencer.md
Name: neuron_train_sequencer

Overview:
Multi-epoch training sequencer for the perceptron neuron datapath: the X1/X2/t registers, the 14-bit W1/W2/Bias registers, the Yin register and the equality flag. It walks a sample memory, drives the datapath load and init strobes for each sample, and tracks whether any weight changed during an epoch. It stops on convergence or when an epoch limit is reached, and reports the result to the top-level neuron module.

Parameters:
ADDR_W, 8, sample memory address width; maximum sample count is 2^ADDR_W.
EPOCH_W, 16, width of the epoch counter and epoch limit.

Ports:
clk  input  1  system clock, rising edge.
rstN  input  1  asynchronous active-low reset.
start  input  1  begin training; sampled only in IDLE.
abort  input  1  synchronous abort; return to IDLE without asserting done.
nSamples  input  ADDR_W+1  sample count, latched on start.
maxEpochs  input  EPOCH_W  epoch limit, latched on start; 0 means unlimited.
eqFlag  input  1  datapath flag: activation derived from Yin equals t.
memAddr  output  ADDR_W  sample memory address.
memRdEn  output  1  sample memory read enable; data is valid 1 cycle later.
ldX1, ldX2, ldt  output  1 each  load sample registers from memory data.
ldYin  output  1  load the net-input register.
ldW1, ldW2, ldB  output  1 each  apply the weight/bias update.
initW1, initW2, initB  output  1 each  clear weights and bias.
epochCount  output  EPOCH_W  completed epochs.
busy  output  1  high in every state except IDLE and DONE.
done  output  1  level; high in DONE.
converged  output  1  valid while done is high.

Behaviour:
- Reset (rstN=0, async): state=IDLE. All strobes, memRdEn, busy, done and converged go to 0. memAddr=0, epochCount=0. Latched nSamples and maxEpochs are cleared.
- All strobes are Moore outputs, high for exactly 1 cycle in their state. No two states share a strobe except the ld*/init* groups listed below.
- States and transitions:
  - IDLE: on start=1, latch inputs, go to INIT.
  - INIT (1 cycle): initW1, initW2 and initB high. Clear sampleIdx, epochCount and updFlag. If latched nSamples=0, go to DONE with converged=1. Otherwise go to FETCH.
  - FETCH: memRdEn=1, memAddr=sampleIdx. Go to LOAD.
  - LOAD: ldX1, ldX2 and ldt high. Go to EVAL.
  - EVAL: ldYin high. Go to DECIDE.
  - DECIDE: sample eqFlag. If eqFlag=0, go to UPDATE; if eqFlag=1, go to NEXT.
  - UPDATE: ldW1, ldW2 and ldB high; updFlag<=1. Go to NEXT.
  - NEXT: if sampleIdx==nSamples-1, go to EPOCH. Otherwise sampleIdx<=sampleIdx+1 and go to FETCH.
  - EPOCH:
    - epochCount<=epochCount+1 (saturates at all-ones).
    - If updFlag=0, go to DONE with converged=1.
    - Else if maxEpochs!=0 and epochCount+1==maxEpochs, go to DONE with converged=0.
    - Else clear sampleIdx and updFlag, go to FETCH.
  - DONE: done=1, converged held, epochCount held. On start=1, go to INIT (restart, re-latch inputs). abort has no effect here.
- Latency:
  - 5 cycles per correctly classified sample, 6 per updated sample, plus 1 per epoch.
  - start to first ldX1: 3 cycles (IDLE->INIT->FETCH->LOAD).
- Clamping and saturation:
  - nSamples > 2^ADDR_W is clamped to 2^ADDR_W at latch time.
  - With unlimited epochs, the epoch counter saturates and training continues until convergence.
- start while busy is ignored; inputs are not re-latched.
- abort=1 in any busy state: next state IDLE, done=0, weights untouched. abort has priority over every transition. If abort and start are both high in IDLE, the block stays in IDLE.
- rstN deasserted mid-training: immediate IDLE. Resumption is only via a new start.
- eqFlag is ignored outside DECIDE.

Test Plan:
- Reset mid-UPDATE (assert rstN=0) -> outputs 0 immediately; state IDLE; a later start gives a normal INIT.
- nSamples=0, start -> INIT strobes for 1 cycle, then done=1, converged=1, epochCount=0, with no memRdEn ever asserted.
- nSamples=4, maxEpochs=10, eqFlag forced 1 -> 4 FETCH/LOAD/EVAL sequences and no ldW1. done asserts 23 cycles after start with converged=1 and epochCount=1.
- nSamples=3, maxEpochs=2, eqFlag forced 0 -> 6 ldW1 pulses; memAddr sequence 0,1,2,0,1,2; done with converged=0 and epochCount=2.
- AND-gate training: 4 bipolar samples in memory with the real datapath -> converged=1 within 10 epochs; the final W1, W2 and Bias classify all 4 samples correctly.
- abort asserted during epoch 2 -> IDLE the next cycle; done stays 0; a new start during a busy state is ignored; a start pulse in DONE restarts with initW1 high.
